// File: rtl/pkg_config.sv
// Shared configuration for the RV32M multiply/divide unit: widths, op encoding, FSM states.
// No logic of its own; sizes the datapath and the register-file address ports.
// Operand signedness is decided here so the top and the bench agree on one table.
package pkg_config;

    localparam int DATA_WIDTH   = 32;
    localparam int NUM_REGISTER = 32;
    localparam int REG_AW       = $clog2(NUM_REGISTER);
    localparam int MD_ITER      = DATA_WIDTH;
    localparam int MD_CNT_W     = $clog2(MD_ITER);

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic rs1_is_signed(md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic rs2_is_signed(md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two's-complement conditional negate: magnitude of a signed operand, or sign-corrected result.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency 33 cycles start-to-writeback; divide-by-zero and signed overflow finish in 1.
// start_i is ignored while busy_o is high; flush_i aborts with no writeback.
module muldiv_unit
    import pkg_config::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [REG_AW-1:0]     rd_addr_i,
    output logic                  busy_o,
    output logic                  we_o,
    output logic [REG_AW-1:0]     rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_o
);

    localparam int DW = DATA_WIDTH;

    md_state_e             state_q, state_d;
    md_op_e                op_q, op_d;
    logic [REG_AW-1:0]     rd_addr_q, rd_addr_d;
    logic [DW-1:0]         a_q, a_d;
    logic [DW-1:0]         b_q, b_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic [2*DW-1:0]       prod_q, prod_d;
    logic [DW-1:0]         rem_q, rem_d;
    logic [DW-1:0]         quo_q, quo_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]         rd_q, rd_d;

    md_op_e                op_in;
    logic                  s1_in, s2_in;
    logic [DW-1:0]         rs1_mag, rs2_mag;
    logic                  accept, last_iter;
    logic                  div_zero, div_ovf, fast;
    logic [DW-1:0]         fast_res;

    logic [DW-1:0]         mul_addend;
    logic [DW:0]           mul_sum;
    logic [2*DW-1:0]       prod_step;
    logic [DW:0]           div_shift;
    logic                  div_ge;
    logic [DW-1:0]         rem_step, quo_step;
    logic [2*DW-1:0]       prod_fix;
    logic [DW-1:0]         quo_fix, rem_fix;
    logic [DW-1:0]         final_res;

    assign op_in  = md_op_e'(op_i);
    assign s1_in  = rs1_i[DW-1] & rs1_is_signed(op_in);
    assign s2_in  = rs2_i[DW-1] & rs2_is_signed(op_in);
    assign accept = (state_q == IDLE) && start_i && !flush_i;
    assign last_iter = (cnt_q == MD_CNT_W'(MD_ITER - 1));

    muldiv_sign_fix #(.W(DW)) u_rs1_mag (.val_i(rs1_i), .neg_i(s1_in), .val_o(rs1_mag));
    muldiv_sign_fix #(.W(DW)) u_rs2_mag (.val_i(rs2_i), .neg_i(s2_in), .val_o(rs2_mag));

    // Fast path resolves the RISC-V defined corner results without iterating.
    assign div_zero = op_in[2] && (rs2_i == '0);
    assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM))
                      && (rs1_i == {1'b1, {(DW-1){1'b0}}}) && (&rs2_i);
    assign fast     = div_zero || div_ovf;
    always_comb begin
        fast_res = rs1_i;
        if (op_in[1]) fast_res = div_zero ? rs1_i : '0;
        else          fast_res = div_zero ? '1 : rs1_i;
    end

    // Multiplier lives in the low half of prod_q and is shifted out as the product grows in.
    assign mul_addend = prod_q[0] ? a_q : '0;
    assign mul_sum    = {1'b0, prod_q[2*DW-1:DW]} + {1'b0, mul_addend};
    assign prod_step  = {mul_sum, prod_q[DW-1:1]};

    // Remainder after a successful subtract is below the divisor, so 32 bits hold it.
    assign div_shift = {rem_q, quo_q[DW-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign rem_step  = div_ge ? (div_shift[DW-1:0] - b_q) : div_shift[DW-1:0];
    assign quo_step  = {quo_q[DW-2:0], div_ge};

    muldiv_sign_fix #(.W(2*DW)) u_prod_fix (.val_i(prod_step), .neg_i(s1_q ^ s2_q), .val_o(prod_fix));
    muldiv_sign_fix #(.W(DW))   u_quo_fix  (.val_i(quo_step),  .neg_i(s1_q ^ s2_q), .val_o(quo_fix));
    muldiv_sign_fix #(.W(DW))   u_rem_fix  (.val_i(rem_step),  .neg_i(s1_q),        .val_o(rem_fix));

    always_comb begin
        final_res = prod_fix[DW-1:0];
        case (op_q)
            MD_MUL:                        final_res = prod_fix[DW-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*DW-1:DW];
            MD_DIV, MD_DIVU:               final_res = quo_fix;
            MD_REM, MD_REMU:               final_res = rem_fix;
            default:                       final_res = prod_fix[DW-1:0];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : CALC;
            CALC:    if (flush_i) state_d = IDLE;
                     else if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        we_o   = (state_q == DONE) && (rd_addr_q != '0);
    end

    always_comb begin
        op_d      = op_q;
        rd_addr_d = rd_addr_q;
        a_d       = a_q;
        b_d       = b_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        if (accept) begin
            op_d      = op_in;
            rd_addr_d = rd_addr_i;
            a_d       = rs1_mag;
            b_d       = rs2_mag;
            s1_d      = s1_in;
            s2_d      = s2_in;
            prod_d    = {{DW{1'b0}}, rs2_mag};
            rem_d     = '0;
            quo_d     = rs1_mag;
            cnt_d     = '0;
            if (fast) rd_d = fast_res;
        end else if ((state_q == CALC) && !flush_i) begin
            prod_d = prod_step;
            rem_d  = rem_step;
            quo_d  = quo_step;
            cnt_d  = cnt_q + MD_CNT_W'(1);
            if (last_iter) rd_d = final_res;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= MD_MUL;
            rd_addr_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
        end else begin
            op_q      <= op_d;
            rd_addr_q <= rd_addr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
        end
    end

    assign rd_o      = rd_q;
    assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of RV32M ops with hand-computed results,
// plus sequences for start-while-busy, flush, x0 destination and async reset.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam int NV = 19;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o, we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk_i = ~clk_i;

    muldiv_unit dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .flush_i   (flush_i),
        .op_i      (op_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .rd_addr_i (rd_addr_i),
        .busy_o    (busy_o),
        .we_o      (we_o),
        .rd_addr_o (rd_addr_o),
        .rd_o      (rd_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1; the following edge is E0. Operands are scrambled right after E0.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
        @(posedge clk_i); #1;
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
        op_i = 3'($urandom); rd_addr_i = 5'($urandom);
    endtask

    // Sample k is taken 1 time unit after edge Ek; k=0 is the sample right after E0.
    task automatic observe(input int ncyc, output int first_we, output int n_we,
                           output logic [31:0] res, output logic [4:0] addr, output int last_busy);
        first_we = -1; n_we = 0; res = '0; addr = '0; last_busy = -1;
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) begin
                @(posedge clk_i); #1;
            end
            if (busy_o) last_busy = k;
            if (we_o) begin
                n_we++;
                if (first_we < 0) begin
                    first_we = k; res = rd_o; addr = rd_addr_o;
                end
            end
        end
    endtask

    initial begin
        int          first_we, n_we, last_busy;
        logic [31:0] res, held;
        logic [4:0]  addr;

        vecs[0]  = '{OP_MUL,    32'd7,        32'd6,        5'd5,  32'h0000002A, 1'b0};
        vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 1'b0};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        5'd7,  32'h0000000E, 1'b0};
        vecs[7]  = '{OP_DIVU,   32'h00001234, 32'd0,        5'd8,  32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h00000000, 1'b1};
        vecs[9]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b1};
        vecs[10] = '{OP_REMU,   32'h00001234, 32'd0,        5'd11, 32'h00001234, 1'b1};
        vecs[11] = '{OP_MUL,    32'hFFFFFFFD, 32'd5,        5'd12, 32'hFFFFFFF1, 1'b0};
        vecs[12] = '{OP_MULH,   32'hFFFFFFFD, 32'd5,        5'd13, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{OP_REMU,   32'd100,      32'd7,        5'd14, 32'h00000002, 1'b0};
        vecs[14] = '{OP_DIV,    32'd20,       32'hFFFFFFFD, 5'd15, 32'hFFFFFFFA, 1'b0};
        vecs[15] = '{OP_REM,    32'd20,       32'hFFFFFFFD, 5'd16, 32'h00000002, 1'b0};
        vecs[16] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        5'd17, 32'hFFFFFFFF, 1'b0};
        vecs[17] = '{OP_DIV,    32'h80000000, 32'd1,        5'd18, 32'h80000000, 1'b0};
        vecs[18] = '{OP_MULHU,  32'h80000000, 32'd2,        5'd31, 32'h00000001, 1'b0};

        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset busy_o", 32'(busy_o), 32'd0);
        check("reset we_o", 32'(we_o), 32'd0);
        check("reset rd_o", rd_o, 32'd0);
        check("reset rd_addr_o", 32'(rd_addr_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            observe(40, first_we, n_we, res, addr, last_busy);
            check($sformatf("v%0d result", i), res, vecs[i].exp);
            check($sformatf("v%0d rd_addr_o", i), 32'(addr), 32'(vecs[i].rd));
            check($sformatf("v%0d we count", i), 32'(n_we), 32'd1);
            check($sformatf("v%0d we cycle", i), 32'(first_we), vecs[i].fast ? 32'd0 : 32'd32);
            check($sformatf("v%0d busy end", i), 32'(last_busy), vecs[i].fast ? 32'd0 : 32'd32);
        end

        // x0 destination: full-length run, no write pulse
        launch(OP_MUL, 32'd7, 32'd6, 5'd0);
        observe(40, first_we, n_we, res, addr, last_busy);
        check("x0 we count", 32'(n_we), 32'd0);
        check("x0 busy end", 32'(last_busy), 32'd32);

        // start held high from cycle 10 through DONE must not launch a second op
        launch(OP_MUL, 32'd7, 32'd6, 5'd5);
        n_we = 0; res = '0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk_i); #1;
            if (we_o) begin
                n_we++; res = rd_o;
            end
            if (k == 10) begin
                start_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd50; rs2_i = 32'd5; rd_addr_i = 5'd20;
            end
            if (k == 33) start_i = 1'b0;
            if (k == 34) check("restart busy after done", 32'(busy_o), 32'd0);
        end
        check("restart we count", 32'(n_we), 32'd1);
        check("restart result", res, 32'h0000002A);

        // flush at cycle 15 aborts; rd_o keeps its previous value
        held = rd_o;
        launch(OP_MUL, 32'd3, 32'd3, 5'd9);
        n_we = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (we_o) n_we++;
            if (k == 15) flush_i = 1'b1;
            if (k == 16) begin
                flush_i = 1'b0;
                check("flush busy drop", 32'(busy_o), 32'd0);
            end
        end
        check("flush we count", 32'(n_we), 32'd0);
        check("flush rd_o held", rd_o, held);

        // flush with start in IDLE: nothing accepted
        start_i = 1'b1; flush_i = 1'b1; op_i = OP_MUL; rs1_i = 32'd2; rs2_i = 32'd2; rd_addr_i = 5'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0; flush_i = 1'b0;
        check("flush+start busy", 32'(busy_o), 32'd0);
        check("flush+start we", 32'(we_o), 32'd0);

        // async reset mid-CALC, between clock edges
        launch(OP_DIVU, 32'd1000, 32'd7, 5'd4);
        repeat (10) @(posedge clk_i);
        #3;
        check("pre-reset busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("async reset busy", 32'(busy_o), 32'd0);
        check("async reset we", 32'(we_o), 32'd0);
        check("async reset rd_o", rd_o, 32'd0);
        check("async reset rd_addr_o", 32'(rd_addr_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        launch(OP_DIVU, 32'd9, 32'd3, 5'd6);
        observe(40, first_we, n_we, res, addr, last_busy);
        check("post-reset result", res, 32'd3);
        check("post-reset we count", 32'(n_we), 32'd1);
        check("post-reset we cycle", 32'(first_we), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
